// File: rtl/redas_pe_pkg.sv
// Shared types, mode encodings and helpers for the ReDAS PE control sequencer.
package redas_pe_pkg;

  typedef enum logic [1:0] {
    RB_WEIGHT = 2'd0,
    RB_OUTPUT = 2'd1,
    RB_INPUT  = 2'd2
  } redas_pe_roundabout_e;

  typedef enum logic [1:0] {
    SA_FIRST  = 2'd0,
    SA_SECOND = 2'd1,
    SA_THIRD  = 2'd2,
    SA_FOURTH = 2'd3
  } redas_pe_subarray_e;

  typedef enum logic [1:0] {
    ROLE_ORTHOGONAL = 2'd0,
    ROLE_PARALLEL   = 2'd1,
    ROLE_DIAGONAL   = 2'd2
  } redas_pr_role_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_e;

  localparam logic [1:0] DF_ILLEGAL     = 2'd3;
  localparam logic [4:0] CPM_IDLE       = 5'b11000;
  localparam logic [4:0] CPM_LOAD       = 5'b11010;
  localparam logic [4:0] CPM_DRAIN      = 5'b10000;
  localparam logic [4:0] CPM_COMPUTE_WS = 5'b00111;
  localparam logic [4:0] CPM_COMPUTE_OS = 5'b00101;
  localparam logic [4:0] CPM_COMPUTE_IS = 5'b00110;

  // Horizontal bit in [0], vertical bit in [1]; each direction disabled when set.
  function automatic logic [3:0] dmm_for_subarray(input logic [1:0] sa);
    return {~sa[1], ~sa[0], ~sa[1], ~sa[0]};
  endfunction

  // Next phase with a non-zero length after 'cur', falling through to DONE.
  function automatic seq_state_e next_phase(input seq_state_e cur, input logic load_nz,
                                            input logic comp_nz, input logic drain_nz);
    seq_state_e nxt;
    nxt = ST_DONE;
    case (cur)
      ST_IDLE: begin
        if (load_nz)       nxt = ST_LOAD;
        else if (comp_nz)  nxt = ST_COMPUTE;
        else if (drain_nz) nxt = ST_DRAIN;
      end
      ST_LOAD: begin
        if (comp_nz)       nxt = ST_COMPUTE;
        else if (drain_nz) nxt = ST_DRAIN;
      end
      ST_COMPUTE: begin
        if (drain_nz)      nxt = ST_DRAIN;
      end
      default: nxt = ST_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/redas_pe_ctrl_sequencer.sv
// Per-tile LOAD/COMPUTE/DRAIN sequencer driving the configuration inputs of a ReDAS PE.
module redas_pe_ctrl_sequencer
  import redas_pe_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_dataflow,
  input  logic [1:0]           cmd_subarray,
  input  logic [1:0]           cmd_role,
  input  logic [CNT_WIDTH-1:0] cmd_load_len,
  input  logic [CNT_WIDTH-1:0] cmd_compute_len,
  input  logic [CNT_WIDTH-1:0] cmd_drain_len,
  input  logic                 hold,
  output logic [3:0]           data_movement_mode,
  output logic [4:0]           calculation_pattern_mode,
  output logic                 enable_right_angle_movement,
  output logic                 store_stationary,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_error
);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] load_len_q, load_len_d;
  logic [CNT_WIDTH-1:0] compute_len_q, compute_len_d;
  logic [CNT_WIDTH-1:0] drain_len_q, drain_len_d;
  logic [CNT_WIDTH-1:0] entry_len;
  logic [1:0]           df_q, df_d, sa_q, sa_d, role_q, role_d;
  logic                 ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic                 err_q, err_d, store_q, store_d, erm_q, erm_d;
  logic [3:0]           dmm_q, dmm_d;
  logic [4:0]           cpm_q, cpm_d;
  logic                 accept, drain_nz, in_phase;

  assign accept = cmd_valid & ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_len_d    = load_len_q;
    compute_len_d = compute_len_q;
    drain_len_d   = drain_len_q;
    df_d          = df_q;
    sa_d          = sa_q;
    role_d        = role_q;
    err_d         = 1'b0;
    entry_len     = '0;
    drain_nz      = 1'b0;

    if (state_q == ST_IDLE && accept && cmd_dataflow != DF_ILLEGAL) begin
      load_len_d    = cmd_load_len;
      compute_len_d = cmd_compute_len;
      drain_len_d   = cmd_drain_len;
      df_d          = cmd_dataflow;
      sa_d          = cmd_subarray;
      role_d        = cmd_role;
    end
    // DRAIN only exists for output-stationary tiles.
    drain_nz = (drain_len_d != '0) && (df_d == RB_OUTPUT);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_dataflow == DF_ILLEGAL) err_d = 1'b1;
          else state_d = next_phase(ST_IDLE, load_len_d != '0, compute_len_d != '0, drain_nz);
        end
      end
      ST_LOAD, ST_COMPUTE, ST_DRAIN: begin
        if (!hold) begin
          if (cnt_q == '0)
            state_d = next_phase(state_q, load_len_d != '0, compute_len_d != '0, drain_nz);
          else
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_LOAD:    entry_len = load_len_d;
      ST_COMPUTE: entry_len = compute_len_d;
      ST_DRAIN:   entry_len = drain_len_d;
      default:    entry_len = '0;
    endcase
    if (state_d != state_q)
      cnt_d = (entry_len == '0) ? '0 : entry_len - CNT_WIDTH'(1);

    // Outputs are decoded from the next state so they line up with it after the edge.
    in_phase = (state_d == ST_LOAD) || (state_d == ST_COMPUTE) || (state_d == ST_DRAIN);
    ready_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    erm_d    = in_phase && (role_d != ROLE_PARALLEL);
    store_d  = (state_d == ST_LOAD) || (state_d == ST_COMPUTE && df_d == RB_OUTPUT);
    dmm_d    = (state_d == ST_IDLE) ? dmm_q : dmm_for_subarray(sa_d);
    case (state_d)
      ST_LOAD:    cpm_d = CPM_LOAD;
      ST_DRAIN:   cpm_d = CPM_DRAIN;
      ST_COMPUTE: cpm_d = (df_d == RB_WEIGHT) ? CPM_COMPUTE_WS :
                          (df_d == RB_OUTPUT) ? CPM_COMPUTE_OS : CPM_COMPUTE_IS;
      default:    cpm_d = CPM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      load_len_q    <= '0;
      compute_len_q <= '0;
      drain_len_q   <= '0;
      df_q          <= '0;
      sa_q          <= '0;
      role_q        <= '0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      store_q       <= 1'b0;
      erm_q         <= 1'b0;
      dmm_q         <= 4'b1111;
      cpm_q         <= CPM_IDLE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_len_q    <= load_len_d;
      compute_len_q <= compute_len_d;
      drain_len_q   <= drain_len_d;
      df_q          <= df_d;
      sa_q          <= sa_d;
      role_q        <= role_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      store_q       <= store_d;
      erm_q         <= erm_d;
      dmm_q         <= dmm_d;
      cpm_q         <= cpm_d;
    end
  end

  assign cmd_ready                   = ready_q;
  assign busy                        = busy_q;
  assign done                        = done_q;
  assign cmd_error                   = err_q;
  assign data_movement_mode          = dmm_q;
  assign calculation_pattern_mode    = cpm_q;
  assign enable_right_angle_movement = erm_q;
  // A stalled array must never latch stationary data, so hold gates this in the same cycle.
  assign store_stationary            = store_q & ~hold;

endmodule

// File: tb/tb_redas_pe_ctrl_sequencer.sv
// Randomised and directed bench for redas_pe_ctrl_sequencer against a phase-list model.
module tb_redas_pe_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_dataflow = 2'd0, cmd_subarray = 2'd0, cmd_role = 2'd0;
  logic [7:0] cmd_load_len = 8'd0, cmd_compute_len = 8'd0, cmd_drain_len = 8'd0;
  logic       hold = 1'b0;
  logic [3:0] data_movement_mode;
  logic [4:0] calculation_pattern_mode;
  logic       enable_right_angle_movement, store_stationary, busy, done, cmd_error;

  redas_pe_ctrl_sequencer #(.CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dataflow(cmd_dataflow), .cmd_subarray(cmd_subarray), .cmd_role(cmd_role),
    .cmd_load_len(cmd_load_len), .cmd_compute_len(cmd_compute_len),
    .cmd_drain_len(cmd_drain_len), .hold(hold),
    .data_movement_mode(data_movement_mode),
    .calculation_pattern_mode(calculation_pattern_mode),
    .enable_right_angle_movement(enable_right_angle_movement),
    .store_stationary(store_stationary), .busy(busy), .done(done), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // Model: the tile is a list of phases, each with its own pattern and non-held cycle count.
  typedef struct {
    logic [4:0] cpm;
    bit         st;
    bit         erm;
    bit         dn;
    int         n;
  } ent_t;

  ent_t       q[$];
  bit         err_exp = 0;
  logic [3:0] dmm_exp = 4'b1111;
  logic [3:0] dmm_tab [4] = '{4'b1111, 4'b1010, 4'b0101, 4'b0000};
  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0, acc_cnt = 0, done_cyc = 0, err_cnt = 0, busy_cnt = 0;
  bit done_flag = 0;
  logic [3:0] dmm_at_done = 4'h0;
  int hist [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic build_tile();
    logic [4:0] ccpm;
    bit         e;
    e = (cmd_role != 2'd1);
    ccpm = (cmd_dataflow == 2'd0) ? 5'b00111 : (cmd_dataflow == 2'd1) ? 5'b00101 : 5'b00110;
    if (cmd_load_len != 0)    q.push_back('{5'b11010, 1'b1, e, 1'b0, int'(cmd_load_len)});
    if (cmd_compute_len != 0) q.push_back('{ccpm, cmd_dataflow == 2'd1, e, 1'b0, int'(cmd_compute_len)});
    if (cmd_dataflow == 2'd1 && cmd_drain_len != 0)
      q.push_back('{5'b10000, 1'b0, e, 1'b0, int'(cmd_drain_len)});
    q.push_back('{5'b11000, 1'b0, 1'b0, 1'b1, 1});
    dmm_exp = dmm_tab[cmd_subarray];
  endtask

  task automatic tick();
    ent_t h;
    bit e_busy;
    @(negedge clk);
    cyc++;
    e_busy = (q.size() != 0);
    if (e_busy) h = q[0];
    else h = '{5'b11000, 1'b0, 1'b0, 1'b0, 0};
    chk("cmd_ready", cmd_ready, !e_busy);
    chk("busy", busy, e_busy);
    chk("done", done, h.dn);
    chk("cmd_error", cmd_error, err_exp);
    chk("cpm", calculation_pattern_mode, h.cpm);
    chk("erm", enable_right_angle_movement, h.erm);
    chk("store", store_stationary, h.st & ~hold);
    if (e_busy) chk("dmm", data_movement_mode, dmm_exp);
    if (busy === 1'b1) begin
      busy_cnt++;
      hist[calculation_pattern_mode]++;
    end
    if (cmd_error === 1'b1) err_cnt++;
    if (done === 1'b1) begin
      done_flag = 1;
      done_cyc = cyc;
      dmm_at_done = data_movement_mode;
    end
    if (rst) begin
      q.delete();
      err_exp = 0;
      dmm_exp = 4'b1111;
    end else begin
      err_exp = 0;
      if (q.size() != 0) begin
        h = q[0];
        if (h.dn || !hold) begin
          h.n--;
          if (h.n == 0) void'(q.pop_front());
          else q[0] = h;
        end
      end else if (cmd_valid) begin
        if (cmd_dataflow == 2'd3) err_exp = 1;
        else begin
          build_tile();
          acc_cyc = cyc;
          acc_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    foreach (hist[i]) hist[i] = 0;
    done_flag = 0;
    err_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic run_until_done(input string name);
    done_flag = 0;
    for (int i = 0; i < 60 && !done_flag; i++) tick();
    if (!done_flag) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic issue(input logic [1:0] df, input logic [1:0] sa, input logic [1:0] role,
                       input logic [7:0] l, input logic [7:0] c, input logic [7:0] d);
    cmd_dataflow = df; cmd_subarray = sa; cmd_role = role;
    cmd_load_len = l; cmd_compute_len = c; cmd_drain_len = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int acc1, done1, budget;
    foreach (hist[i]) hist[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_cpm", calculation_pattern_mode, 5'b11000);
    chk("rst_dmm", data_movement_mode, 4'b1111);
    tick();

    // WEIGHT, FIRST, PARALLEL, 3/4/5
    clr_stats();
    issue(2'd0, 2'd0, 2'd1, 8'd3, 8'd4, 8'd5);
    run_until_done("ws");
    chk("ws_done_ofs", done_cyc - acc_cyc, 8);
    chk("ws_load_cycles", hist[5'b11010], 3);
    chk("ws_comp_cycles", hist[5'b00111], 4);
    chk("ws_drain_cycles", hist[5'b10000], 0);
    chk("ws_dmm", dmm_at_done, 4'b1111);
    tick();

    // OUTPUT, FOURTH, DIAGONAL, 0/2/2
    clr_stats();
    issue(2'd1, 2'd3, 2'd2, 8'd0, 8'd2, 8'd2);
    run_until_done("os");
    chk("os_done_ofs", done_cyc - acc_cyc, 5);
    chk("os_comp_cycles", hist[5'b00101], 2);
    chk("os_drain_cycles", hist[5'b10000], 2);
    chk("os_dmm", dmm_at_done, 4'b0000);

    // INPUT 2/3/0 stalled 4 cycles mid-COMPUTE
    clr_stats();
    issue(2'd2, 2'd1, 2'd0, 8'd2, 8'd3, 8'd0);
    repeat (3) tick();
    hold = 1'b1;
    repeat (4) tick();
    hold = 1'b0;
    run_until_done("is");
    chk("is_done_ofs", done_cyc - acc_cyc, 10);
    chk("is_comp_cycles", hist[5'b00110], 7);

    // All-zero lengths go straight to DONE
    clr_stats();
    issue(2'd0, 2'd2, 2'd0, 8'd0, 8'd0, 8'd7);
    run_until_done("zero");
    chk("zero_done_ofs", done_cyc - acc_cyc, 1);
    chk("zero_phase_cycles", hist[5'b11010] + hist[5'b00111] + hist[5'b10000], 0);

    // Illegal dataflow
    clr_stats();
    issue(2'd3, 2'd0, 2'd0, 8'd2, 8'd2, 8'd2);
    repeat (4) tick();
    chk("ill_err_pulses", err_cnt, 1);
    chk("ill_busy_cycles", busy_cnt, 0);

    // Back-to-back with cmd_valid held through busy
    clr_stats();
    cmd_dataflow = 2'd0; cmd_subarray = 2'd1; cmd_role = 2'd2;
    cmd_load_len = 8'd1; cmd_compute_len = 8'd1; cmd_drain_len = 8'd0;
    cmd_valid = 1'b1;
    budget = acc_cnt;
    tick();
    acc1 = acc_cyc;
    chk("b2b_first_accept", acc_cnt - budget, 1);
    cmd_subarray = 2'd2;
    for (int i = 0; i < 20 && acc_cnt == budget + 1; i++) tick();
    done1 = done_cyc;
    chk("b2b_dmm1", dmm_at_done, 4'b1010);
    cmd_valid = 1'b0;
    chk("b2b_acc_after_done", acc_cyc - done1, 1);
    chk("b2b_acc_gap", acc_cyc - acc1, 4);
    run_until_done("b2b");
    chk("b2b_dmm2", dmm_at_done, 4'b0101);

    // Reset asserted for two cycles in the middle of COMPUTE
    issue(2'd0, 2'd0, 2'd0, 8'd2, 8'd10, 8'd0);
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cpm", calculation_pattern_mode, 5'b11000);
    chk("mid_rst_dmm", data_movement_mode, 4'b1111);
    chk("mid_rst_store", store_stationary, 0);
    tick();

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      cmd_valid    = $urandom_range(0, 1);
      cmd_dataflow = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cmd_subarray = 2'($urandom_range(0, 3));
      cmd_role     = 2'($urandom_range(0, 2));
      cmd_load_len    = 8'($urandom_range(0, 4));
      cmd_compute_len = 8'($urandom_range(0, 5));
      cmd_drain_len   = 8'($urandom_range(0, 4));
      hold         = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    hold = 1'b0;
    repeat (30) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/redas_pe_ctrl_sequencer.md
Name: redas_pe_ctrl_sequencer

Overview:
- Drives the per-PE configuration inputs of the ReDAS roundabout processing element: data_movement_mode, calculation_pattern_mode, enable_right_angle_movement and store_stationary.
- Accepts one dataflow command per tile through a valid/ready handshake.
- Steps through LOAD, COMPUTE and DRAIN phases with cycle-exact registered control outputs.
- One instance per PE column or subarray; it sits between the tile scheduler and the PE array.

Parameters:
- CNT_WIDTH, 8, width of each phase-length field and of the internal cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_dataflow  in  2  redas_pe_roundabout_e: WEIGHT=0, OUTPUT=1, INPUT=2. Value 3 is illegal.
- cmd_subarray  in  2  redas_pe_subarray_e: FIRST..FOURTH.
- cmd_role  in  2  redas_pr_role_e: ORTHOGONAL, PARALLEL, DIAGONAL.
- cmd_load_len  in  CNT_WIDTH  LOAD phase cycles.
- cmd_compute_len  in  CNT_WIDTH  COMPUTE phase cycles.
- cmd_drain_len  in  CNT_WIDTH  DRAIN phase cycles; used only for OUTPUT dataflow.
- hold  in  1  array stall.
- data_movement_mode  out  4  to PE.
- calculation_pattern_mode  out  5  to PE.
- enable_right_angle_movement  out  1  to PE.
- store_stationary  out  1  to PE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  single-cycle pulse at tile completion.
- cmd_error  out  1  single-cycle pulse when an illegal dataflow is rejected.

Behaviour:
- Reset (rst=1 at a clk edge), including mid-operation:
  - State goes to IDLE and all counters clear.
  - Outputs: cmd_ready=1, busy=0, done=0, cmd_error=0, store_stationary=0, data_movement_mode=4'b1111, calculation_pattern_mode=CPM_IDLE (5'b11000), enable_right_angle_movement=0.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- Command acceptance:
  - cmd_ready=1 only in IDLE.
  - Acceptance happens on cmd_valid&cmd_ready; all fields are latched at that edge.
  - If cmd_dataflow=3, the sequencer pulses cmd_error the next cycle and stays in IDLE.
- Next-state rule from IDLE on acceptance: first non-zero phase in the order LOAD, COMPUTE, DRAIN. DRAIN counts only when dataflow=OUTPUT. If no phase is non-zero, go directly to DONE.
- Phase duration:
  - Each phase lasts exactly its length in non-held cycles.
  - The counter loads len-1 on phase entry and decrements when hold=0.
  - At 0 with hold=0, advance to the next non-zero phase, or to DONE.
- DONE: lasts one cycle with done=1, then returns to IDLE. A new command can be accepted on the following cycle.
- Latency: all outputs are registered and reflect the state they belong to. The first LOAD cycle appears on the outputs at the edge after acceptance.
- data_movement_mode, held constant for the whole tile:
  - Formula: {~v,~h,~v,~h}, where h=subarray[0] and v=subarray[1].
  - Resulting values: FIRST=1111, SECOND=1010, THIRD=0101, FOURTH=0000.
- enable_right_angle_movement: (role != PARALLEL) during LOAD, COMPUTE and DRAIN; 0 in IDLE and DONE.
- calculation_pattern_mode:
  - LOAD: CPM_LOAD=5'b11010.
  - COMPUTE, WEIGHT: 5'b00111.
  - COMPUTE, OUTPUT: 5'b00101.
  - COMPUTE, INPUT: 5'b00110.
  - DRAIN: CPM_DRAIN=5'b10000.
  - IDLE and DONE: CPM_IDLE.
- store_stationary:
  - 1 in LOAD.
  - 1 in COMPUTE only for OUTPUT dataflow.
  - 0 in all other states.
  - Forced to 0 on any cycle with hold=1.
- hold:
  - Freezes state and counter.
  - Mode outputs keep their values.
  - Has no effect in IDLE or DONE; done is never stretched.
- Length fields: unsigned, maximum 2^CNT_WIDTH-1; no wrap past 0.

Decomposition:
- Package redas_pe_pkg holds:
  - the enums redas_pe_roundabout_e, redas_pe_subarray_e and redas_pr_role_e, moved here from the PE file;
  - constants CPM_IDLE, CPM_LOAD, CPM_DRAIN, CPM_COMPUTE_WS, CPM_COMPUTE_OS, CPM_COMPUTE_IS;
  - the function dmm_for_subarray().
- No sub-module. One combinational decode block plus a registered output stage.

Test Plan:
- Reset check: assert rst for 2 cycles mid-COMPUTE -> next cycle state is IDLE, cmd_ready=1, all outputs at their reset values.
- WEIGHT tile: dataflow=WEIGHT, subarray=FIRST, role=PARALLEL, lengths load/compute/drain=3/4/5 ->
  - 3 cycles CPM 11010 with store=1;
  - 4 cycles CPM 00111 with store=0; no DRAIN;
  - done pulse on cycle 8 after acceptance;
  - dmm=1111 and erm=0 throughout.
- OUTPUT tile: dataflow=OUTPUT, subarray=FOURTH, role=DIAGONAL, lengths 0/2/2 ->
  - LOAD skipped;
  - 2 cycles CPM 00101 with store=1, then 2 cycles CPM 10000 with store=0;
  - dmm=0000 and erm=1; done on cycle 5.
- Stall: INPUT tile with lengths 2/3/0, hold high for 4 cycles in mid-COMPUTE -> COMPUTE lasts 7 cycles, store=0 while held, done on cycle 10 after acceptance.
- Edge commands:
  - all lengths 0 -> DONE on the next cycle, done pulse, no LOAD/COMPUTE outputs;
  - cmd_dataflow=3 -> cmd_error pulse, busy stays 0;
  - cmd_valid held during busy -> not accepted until the cycle after done.
- Back-to-back: two SECOND/THIRD commands, each with lengths 1/1/0, issued with cmd_valid held high -> dmm 1010, then 0101; second acceptance one cycle after the first done.
